hazard_grid_sequencer: RTL and testbench

HAZARD_GRID_SEQUENCER -- requirements
Module: hazard_grid_sequencer

---
 rtl/hazard_grid_pkg.sv | 27 ++
 rtl/hazard_cell_mask.sv | 22 ++
 rtl/hazard_grid_sequencer.sv | 118 +++++++++++
 tb/tb_hazard_grid_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_grid_pkg.sv
// Shared geometry constants, box record and sequencer state encoding for the hazard grid.
// The grid is 4 rows x 8 columns of 93x155-pixel cells over a 1240x375 image.
package hazard_grid_pkg;

  localparam int IMG_WIDTH   = 1240;
  localparam int IMG_HEIGHT  = 375;
  localparam int CELL_WIDTH  = 155;
  localparam int CELL_HEIGHT = 93;
  localparam int GRID_ROWS   = 4;
  localparam int GRID_COLS   = 8;
  localparam int COORD_W     = 11;
  localparam int NUM_CELLS   = GRID_ROWS * GRID_COLS;

  typedef struct packed {
    logic [COORD_W-1:0] top;
    logic [COORD_W-1:0] left;
    logic [COORD_W-1:0] bottom;
    logic [COORD_W-1:0] right;
  } hazard_box_t;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_OUT   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/hazard_cell_mask.sv
// Combinational box-to-cell overlap mask: bit r*8+c is set when the box touches cell (r,c).
// Coordinates past the last row/column simply match no cell.
module hazard_cell_mask
  import hazard_grid_pkg::*;
(
  input  hazard_box_t          i_box,
  output logic [NUM_CELLS-1:0] o_mask
);

  for (genvar r = 0; r < GRID_ROWS; r++) begin : g_row
    for (genvar c = 0; c < GRID_COLS; c++) begin : g_col
      localparam logic [COORD_W-1:0] ROW_TOP = COORD_W'(r * CELL_HEIGHT);
      localparam logic [COORD_W-1:0] ROW_BOT = COORD_W'(r * CELL_HEIGHT + CELL_HEIGHT - 1);
      localparam logic [COORD_W-1:0] COL_LFT = COORD_W'(c * CELL_WIDTH);
      localparam logic [COORD_W-1:0] COL_RGT = COORD_W'(c * CELL_WIDTH + CELL_WIDTH - 1);

      assign o_mask[r*GRID_COLS + c] = !((i_box.bottom < ROW_TOP) || (i_box.top > ROW_BOT) ||
                                         (i_box.right < COL_LFT) || (i_box.left > COL_RGT));
    end
  end

endmodule

// File: rtl/hazard_grid_sequencer.sv
// Buffers a frame of hazard boxes, ORs their cell masks one per cycle, then holds the 32-cell result until taken.
// Optional HAZARD_OVF_FLAG_EN adds an ovf output flagging boxes dropped because the buffer was full.
module hazard_grid_sequencer
  import hazard_grid_pkg::*;
#(
  parameter int MAX_HAZARDS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               box_valid,
  output logic               box_ready,
  input  logic [COORD_W-1:0] box_top,
  input  logic [COORD_W-1:0] box_left,
  input  logic [COORD_W-1:0] box_bottom,
  input  logic [COORD_W-1:0] box_right,
  input  logic               box_last,
  output logic               vec_valid,
  input  logic               vec_ready,
  output logic [15:0]        vec1,
  output logic [15:0]        vec2,
  output logic               busy
`ifdef HAZARD_OVF_FLAG_EN
  ,
  output logic               ovf
`endif
);

  localparam int IW = (MAX_HAZARDS > 1) ? $clog2(MAX_HAZARDS) : 1;
  localparam int CW = $clog2(MAX_HAZARDS + 1);

  seq_state_t             r_state;
  seq_state_t             w_next;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  hazard_box_t            r_buf [MAX_HAZARDS];
  logic [NUM_CELLS-1:0]   r_acc;
  logic [NUM_CELLS-1:0]   r_vec;
  logic [NUM_CELLS-1:0]   w_mask;
  logic [NUM_CELLS-1:0]   w_acc_next;
  hazard_box_t            w_box_in;
  logic                   w_accept;
  logic                   w_store;
  logic                   w_scan_done;
  logic                   w_vec_hs;

  assign w_box_in    = '{top: box_top, left: box_left, bottom: box_bottom, right: box_right};
  assign w_accept    = box_valid && (r_state == ST_ACCUM);
  assign w_store     = w_accept && (r_cnt < CW'(MAX_HAZARDS));
  assign w_scan_done = (r_state == ST_SCAN) && (CW'(r_idx) == (r_cnt - CW'(1)));
  assign w_vec_hs    = (r_state == ST_OUT) && vec_ready;
  assign w_acc_next  = r_acc | w_mask;

  hazard_cell_mask u_cell_mask (
    .i_box  (r_buf[r_idx]),
    .o_mask (w_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_ACCUM;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ACCUM: if (w_accept && box_last) w_next = ST_SCAN;
      ST_SCAN:  if (w_scan_done)          w_next = ST_OUT;
      ST_OUT:   if (vec_ready)            w_next = ST_ACCUM;
      default:                            w_next = ST_ACCUM;
    endcase
  end

  // Buffer holds no reset: slots are always written before being scanned.
  always_ff @(posedge clk) begin
    if (w_store) r_buf[r_cnt[IW-1:0]] <= w_box_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_acc <= '0;
      r_vec <= '0;
    end else begin
      if (w_store) r_cnt <= r_cnt + CW'(1);
      if (w_accept && box_last) r_idx <= '0;
      if (r_state == ST_SCAN) begin
        r_acc <= w_acc_next;
        r_idx <= r_idx + IW'(1);
        if (w_scan_done) r_vec <= w_acc_next;
      end
      if (w_vec_hs) begin
        r_cnt <= '0;
        r_acc <= '0;
        r_vec <= '0;
      end
    end
  end

`ifdef HAZARD_OVF_FLAG_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_ovf <= 1'b0;
    else if (w_vec_hs)             r_ovf <= 1'b0;
    else if (w_accept && !w_store) r_ovf <= 1'b1;
  end

  assign ovf = r_ovf;
`endif

  assign box_ready = (r_state == ST_ACCUM);
  assign busy      = (r_state != ST_ACCUM);
  assign vec_valid = (r_state == ST_OUT);
  assign vec1      = r_vec[15:0];
  assign vec2      = r_vec[31:16];

endmodule

// File: tb/tb_hazard_grid_sequencer.sv
// Directed bench for hazard_grid_sequencer: frame-level model checked every cycle plus literal expectations.
module tb_hazard_grid_sequencer;
  import hazard_grid_pkg::*;

  localparam int MAXH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        box_valid = 1'b0;
  logic        box_last = 1'b0;
  logic        vec_ready = 1'b0;
  logic [10:0] box_top = '0, box_left = '0, box_bottom = '0, box_right = '0;
  logic        box_ready, vec_valid, busy;
  logic [15:0] vec1, vec2;
`ifdef HAZARD_OVF_FLAG_EN
  logic        ovf;
`endif

  int checks = 0;
  int failures = 0;

  hazard_grid_sequencer #(.MAX_HAZARDS(MAXH)) dut (
`ifdef HAZARD_OVF_FLAG_EN
    .ovf        (ovf),
`endif
    .clk        (clk),
    .rst        (rst),
    .box_valid  (box_valid),
    .box_ready  (box_ready),
    .box_top    (box_top),
    .box_left   (box_left),
    .box_bottom (box_bottom),
    .box_right  (box_right),
    .box_last   (box_last),
    .vec_valid  (vec_valid),
    .vec_ready  (vec_ready),
    .vec1       (vec1),
    .vec2       (vec2),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Cell k is hit when the box's pixel span intersects the cell's pixel span.
  function automatic logic [31:0] frame_mask_of(input hazard_box_t b);
    logic [31:0] m = '0;
    for (int k = 0; k < 32; k++) begin
      int y0 = (k / 8) * 93;
      int x0 = (k % 8) * 155;
      if (int'(b.bottom) >= y0 && int'(b.top) <= y0 + 92 &&
          int'(b.right) >= x0 && int'(b.left) <= x0 + 154)
        m[k] = 1'b1;
    end
    return m;
  endfunction

  hazard_box_t m_q[$];
  int          m_wait = 0;
  bit          m_out = 0;
  bit          m_ovf = 0;
  logic [31:0] m_vec = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete(); m_wait = 0; m_out = 0; m_ovf = 0; m_vec = '0;
    end else if (m_out) begin
      if (vec_ready) begin
        m_out = 0; m_q.delete(); m_ovf = 0; m_vec = '0;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_out = 1;
        m_vec = '0;
        foreach (m_q[i]) m_vec |= frame_mask_of(m_q[i]);
      end
    end else if (box_valid) begin
      hazard_box_t b;
      b.top = box_top; b.left = box_left; b.bottom = box_bottom; b.right = box_right;
      if (m_q.size() < MAXH) m_q.push_back(b);
      else m_ovf = 1;
      if (box_last) m_wait = m_q.size();
    end
  end

  always @(negedge clk) begin
    chk("m_vec_valid", {31'd0, vec_valid}, {31'd0, m_out});
    chk("m_box_ready", {31'd0, box_ready}, {31'd0, !m_out && m_wait == 0});
    chk("m_busy",      {31'd0, busy},      {31'd0, m_out || m_wait != 0});
    chk("m_vec",       {vec2, vec1},       m_vec);
`ifdef HAZARD_OVF_FLAG_EN
    chk("m_ovf",       {31'd0, ovf},       {31'd0, m_ovf});
`endif
  end

  task automatic push_box(input int t, input int l, input int b, input int r, input logic last);
    box_valid = 1'b1; box_last = last;
    box_top = 11'(t); box_left = 11'(l); box_bottom = 11'(b); box_right = 11'(r);
    @(posedge clk); #1;
    box_valid = 1'b0; box_last = 1'b0;
  endtask

  task automatic wait_result(input string name, input int lat, input logic [15:0] e1, input logic [15:0] e2);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!vec_valid && n < 100);
    chk({name, "_latency"}, 32'(n), 32'(lat));
    chk({name, "_vec1"}, {16'd0, vec1}, {16'd0, e1});
    chk({name, "_vec2"}, {16'd0, vec2}, {16'd0, e2});
  endtask

  task automatic handshake(input string name);
    vec_ready = 1'b1;
    @(posedge clk); #1;
    vec_ready = 1'b0;
    chk({name, "_hs_box_ready"}, {31'd0, box_ready}, 32'd1);
    chk({name, "_hs_vec_valid"}, {31'd0, vec_valid}, 32'd0);
    chk({name, "_hs_vec"}, {vec2, vec1}, 32'd0);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec_valid", {31'd0, vec_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_vec", {vec2, vec1}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_box_ready", {31'd0, box_ready}, 32'd1);

    push_box(0, 0, 0, 0, 1'b1);
    wait_result("single_origin", 1, 16'h0001, 16'h0000);
    handshake("single_origin");

    push_box(0, 0, 374, 1239, 1'b1);
    wait_result("full_image", 1, 16'hFFFF, 16'hFFFF);
    handshake("full_image");

    push_box(93, 155, 93, 155, 1'b1);
    wait_result("cell9_corner", 1, 16'h0200, 16'h0000);
    handshake("cell9_corner");

    push_box(92, 154, 93, 155, 1'b1);
    wait_result("four_cell_corner", 1, 16'h0303, 16'h0000);
    handshake("four_cell_corner");

    // Third box straddles the last pixel row; only cell 31 is hit.
    push_box(0, 0, 0, 0, 1'b0);
    push_box(0, 1239, 0, 1239, 1'b0);
    push_box(371, 1239, 374, 1239, 1'b1);
    wait_result("three_box", 3, 16'h0081, 16'h8000);
    for (int i = 0; i < 5; i++) begin
      box_valid = 1'b1; box_last = 1'b1;
      box_top = 11'd0; box_left = 11'd0; box_bottom = 11'd374; box_right = 11'd1239;
      @(posedge clk); #1;
      chk("hold_vec", {vec2, vec1}, 32'h8000_0081);
      chk("hold_box_ready", {31'd0, box_ready}, 32'd0);
      chk("hold_vec_valid", {31'd0, vec_valid}, 32'd1);
    end
    box_valid = 1'b0; box_last = 1'b0;
    handshake("three_box");

    for (int i = 0; i < 16; i++)
      push_box((i / 8) * 93, (i % 8) * 155, (i / 8) * 93, (i % 8) * 155, 1'b0);
    push_box(300, 1000, 374, 1239, 1'b1);
    wait_result("overflow", 16, 16'hFFFF, 16'h0000);
`ifdef HAZARD_OVF_FLAG_EN
    chk("overflow_ovf_set", {31'd0, ovf}, 32'd1);
`endif
    handshake("overflow");
`ifdef HAZARD_OVF_FLAG_EN
    chk("overflow_ovf_clear", {31'd0, ovf}, 32'd0);
`endif

    for (int i = 0; i < 8; i++)
      push_box(0, i * 155, 0, i * 155, (i == 7) ? 1'b1 : 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("scan_busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_vec_valid", {31'd0, vec_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_vec", {vec2, vec1}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_box_ready", {31'd0, box_ready}, 32'd1);
    push_box(92, 154, 93, 155, 1'b1);
    wait_result("after_reset", 1, 16'h0303, 16'h0000);
    handshake("after_reset");

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
